// File: rtl/mc_maindec.sv
// mc_maindec: multicycle main control unit for the 4-bit CPU datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback over a
// shared instruction/data memory with a ready handshake. Also handles a
// multi-cycle divider, traps illegal opcodes and times out stalled memory.
//
// Parameters:
//   OPW     - opcode width (>= 4); opcodes >= 16 are illegal
//   TIMEOUT - max cycles of mem_req without mem_ready before trapping (0 = off)
// Ports:
//   clk, reset           - rising-edge clock, async active-high reset
//   op                   - opcode from the instruction register
//   zero                 - ALU zero flag (drives pcsrc in BRANCH)
//   mem_ready            - memory completed the current request this cycle
//   div_done             - divider result valid
//   mem_req, iord        - memory request, address select (0 PC, 1 ALU)
//   memwrite ... jump    - datapath controls
//   aluop                - 00 add, 01 sub/compare, 10 R-type
//   div_start            - one-cycle divider start pulse
//   instr_done           - pulse on the last cycle of each instruction
//   illegal, bus_err     - sticky trap causes
//   state                - current state encoding (debug)
module mc_maindec #(
  parameter int unsigned OPW     = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic           zero,
  input  logic           mem_ready,
  input  logic           div_done,
  output logic           mem_req,
  output logic           iord,
  output logic           memwrite,
  output logic           irwrite,
  output logic           pcwrite,
  output logic           pcsrc,
  output logic           alusrc,
  output logic           regdst,
  output logic           regwrite,
  output logic           memtoreg,
  output logic           jump,
  output logic [1:0]     aluop,
  output logic           div_start,
  output logic           instr_done,
  output logic           illegal,
  output logic           bus_err,
  output logic [3:0]     state
);

  // Keep at least one counter bit so TIMEOUT=0 still elaborates.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExecR   = 4'd3,
    StDivWait = 4'd4,
    StMemAddr = 4'd5,
    StMemRd   = 4'd6,
    StMemWr   = 4'd7,
    StWbMem   = 4'd8,
    StExecI   = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StTrap    = 4'd12
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              store_q, store_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;

  logic [31:0]       op_ext;
  logic              op_illegal;
  logic [3:0]        opc;
  logic              timeout_hit;
  logic              mem_entry;

  // Zero-extend so the >= 16 test works for any OPW, including OPW = 4.
  assign op_ext     = 32'(op);
  assign op_illegal = (op_ext > 32'd15);
  assign opc        = op[3:0];

  // Trap on the request cycle that would bring the count up to TIMEOUT.
  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT != 0) begin
      timeout_hit = !mem_ready && (cnt_q == CntW'(TIMEOUT - 1));
    end
  end

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    pcsrc      = 1'b0;
    alusrc     = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    jump       = 1'b0;
    aluop      = 2'b00;
    div_start  = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = StDecode;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = StTrap;
        end
      end

      StDecode: begin
        if (op_illegal) begin
          illegal_d = 1'b1;
          state_d   = StTrap;
        end else begin
          case (opc)
            4'd8: begin
              div_start = 1'b1;
              state_d   = StDivWait;
            end
            4'd10, 4'd11: begin
              store_d = (opc == 4'd11);
              state_d = StMemAddr;
            end
            4'd12, 4'd13: state_d = StExecI;
            4'd14:        state_d = StBranch;
            4'd15:        state_d = StJump;
            default:      state_d = StExecR;  // 0-7 and 9
          endcase
        end
      end

      StExecR: begin
        aluop      = 2'b10;
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end

      StDivWait: begin
        aluop  = 2'b10;
        regdst = 1'b1;
        if (div_done) begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
      end

      StMemAddr: begin
        alusrc  = 1'b1;
        state_d = store_q ? StMemWr : StMemRd;
      end

      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        alusrc  = 1'b1;
        if (mem_ready) begin
          state_d = StWbMem;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = StTrap;
        end
      end

      StMemWr: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        alusrc   = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = StFetch;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = StTrap;
        end
      end

      StWbMem: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end

      StExecI: begin
        alusrc     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end

      StBranch: begin
        aluop      = 2'b01;
        pcsrc      = zero;
        instr_done = 1'b1;
        state_d    = StFetch;
      end

      StJump: begin
        jump       = 1'b1;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end

      StTrap: state_d = StTrap;

      default: state_d = StIdle;
    endcase
  end

  // Counter restarts whenever a new memory wait begins or memory answers.
  assign mem_entry = (state_d != state_q) &&
                     ((state_d == StFetch) || (state_d == StMemRd) || (state_d == StMemWr));

  always_comb begin
    cnt_d = cnt_q;
    if (mem_ready || mem_entry) begin
      cnt_d = '0;
    end else if (mem_req) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      store_q   <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      store_q   <= store_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_maindec.sv
// Directed bench for mc_maindec (OPW=5, TIMEOUT=4). Inputs change on the
// falling edge; outputs are sampled 1 time unit later.
module tb_mc_maindec;

  logic       clk;
  logic       reset;
  logic [4:0] op;
  logic       zero, mem_ready, div_done;
  logic       mem_req, iord, memwrite, irwrite, pcwrite, pcsrc, alusrc;
  logic       regdst, regwrite, memtoreg, jump, div_start, instr_done;
  logic [1:0] aluop;
  logic       illegal, bus_err;
  logic [3:0] state;
  logic [14:0] ctl;

  int checks = 0;
  int errors = 0;

  mc_maindec #(.OPW(5), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .div_done(div_done), .mem_req(mem_req), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc), .alusrc(alusrc),
    .regdst(regdst), .regwrite(regwrite), .memtoreg(memtoreg), .jump(jump),
    .aluop(aluop), .div_start(div_start), .instr_done(instr_done),
    .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  assign ctl = {mem_req, iord, memwrite, irwrite, pcwrite, pcsrc, alusrc, regdst,
                regwrite, memtoreg, jump, aluop, div_start, instr_done};

  // Bit order: mem_req iord memwrite irwrite pcwrite pcsrc alusrc regdst
  //            regwrite memtoreg jump aluop[1:0] div_start instr_done
  localparam logic [14:0] C_NONE = 15'b0_0_0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [14:0] C_FR   = 15'b1_0_0_1_1_0_0_0_0_0_0_00_0_0;
  localparam logic [14:0] C_FNR  = 15'b1_0_0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [14:0] C_DS   = 15'b0_0_0_0_0_0_0_0_0_0_0_00_1_0;
  localparam logic [14:0] C_EXR  = 15'b0_0_0_0_0_0_0_1_1_0_0_10_0_1;
  localparam logic [14:0] C_MA   = 15'b0_0_0_0_0_0_1_0_0_0_0_00_0_0;
  localparam logic [14:0] C_MRD  = 15'b1_1_0_0_0_0_1_0_0_0_0_00_0_0;
  localparam logic [14:0] C_WB   = 15'b0_0_0_0_0_0_0_0_1_1_0_00_0_1;
  localparam logic [14:0] C_MWR  = 15'b1_1_1_0_0_0_1_0_0_0_0_00_0_0;
  localparam logic [14:0] C_MWRD = 15'b1_1_1_0_0_0_1_0_0_0_0_00_0_1;
  localparam logic [14:0] C_BR1  = 15'b0_0_0_0_0_1_0_0_0_0_0_01_0_1;
  localparam logic [14:0] C_BR0  = 15'b0_0_0_0_0_0_0_0_0_0_0_01_0_1;
  localparam logic [14:0] C_DW0  = 15'b0_0_0_0_0_0_0_1_0_0_0_10_0_0;
  localparam logic [14:0] C_DW1  = 15'b0_0_0_0_0_0_0_1_1_0_0_10_0_1;
  localparam logic [14:0] C_JMP  = 15'b0_0_0_0_1_0_0_0_0_0_1_00_0_1;
  localparam logic [14:0] C_EXI  = 15'b0_0_0_0_0_0_1_0_1_0_0_00_0_1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leaves the DUT in IDLE with reset just released on a falling edge.
  task automatic apply_reset();
    reset = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0; div_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 5'd3; zero = 1'b1; mem_ready = 1'b1; div_done = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd0 || ctl !== C_NONE) begin
      errors++;
      $display("FAIL reset_state: state=%0d ctl=%b, required state=0 ctl=%b", state, ctl, C_NONE);
    end
    checks++;
    if (illegal !== 1'b0 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: illegal=%b bus_err=%b, required 0 0", illegal, bus_err);
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (state !== 4'd0 || ctl !== C_NONE) begin
      errors++;
      $display("FAIL reset_idle: state=%0d ctl=%b, required state=0 ctl=%b", state, ctl, C_NONE);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd1 || ctl !== C_FR) begin
      errors++;
      $display("FAIL reset_first_fetch: state=%0d ctl=%b, required state=1 ctl=%b", state, ctl, C_FR);
    end
  endtask

  task automatic test_add();
    logic [3:0]  es [4] = '{4'd1, 4'd2, 4'd3, 4'd1};
    logic [14:0] ec [4] = '{C_FR, C_NONE, C_EXR, C_FR};
    apply_reset();
    op = 5'd3; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (state !== es[i] || ctl !== ec[i]) begin
        errors++;
        $display("FAIL add[%0d]: state=%0d ctl=%b, required state=%0d ctl=%b",
                 i, state, ctl, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_load();
    logic [3:0]  es [8] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd6, 4'd6, 4'd8, 4'd1};
    logic        rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [14:0] ec [8] = '{C_FR, C_NONE, C_MA, C_MRD, C_MRD, C_MRD, C_WB, C_FR};
    int done_cnt = 0;
    apply_reset();
    op = 5'd10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); mem_ready = rd[i]; #1;
      checks++;
      if (state !== es[i] || ctl !== ec[i]) begin
        errors++;
        $display("FAIL load[%0d]: state=%0d ctl=%b, required state=%0d ctl=%b",
                 i, state, ctl, es[i], ec[i]);
      end
      if (i < 7) done_cnt += int'(instr_done);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL load_done_count: got %0d instr_done pulses, required 1", done_cnt);
    end
  endtask

  task automatic test_store();
    logic [3:0]  es [6] = '{4'd1, 4'd2, 4'd5, 4'd7, 4'd7, 4'd1};
    logic        rd [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [14:0] ec [6] = '{C_FR, C_NONE, C_MA, C_MWR, C_MWRD, C_FR};
    apply_reset();
    op = 5'd11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); mem_ready = rd[i]; #1;
      checks++;
      if (state !== es[i] || ctl !== ec[i]) begin
        errors++;
        $display("FAIL store[%0d]: state=%0d ctl=%b, required state=%0d ctl=%b",
                 i, state, ctl, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [3:0]  es [7] = '{4'd1, 4'd2, 4'd10, 4'd1, 4'd2, 4'd10, 4'd1};
    logic        zr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [14:0] ec [7] = '{C_FR, C_NONE, C_BR1, C_FR, C_NONE, C_BR0, C_FR};
    apply_reset();
    op = 5'd14; mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); zero = zr[i]; #1;
      checks++;
      if (state !== es[i] || ctl !== ec[i]) begin
        errors++;
        $display("FAIL branch[%0d]: state=%0d ctl=%b, required state=%0d ctl=%b",
                 i, state, ctl, es[i], ec[i]);
      end
    end
    // pcsrc follows zero within the BRANCH cycle
    @(negedge clk); zero = 1'b0; #1;
    @(negedge clk); zero = 1'b0; #1;
    checks++;
    if (state !== 4'd10 || pcsrc !== 1'b0) begin
      errors++;
      $display("FAIL branch_comb_lo: state=%0d pcsrc=%b, required state=10 pcsrc=0", state, pcsrc);
    end
    zero = 1'b1; #1;
    checks++;
    if (pcsrc !== 1'b1) begin
      errors++;
      $display("FAIL branch_comb_hi: pcsrc=%b, required 1", pcsrc);
    end
  endtask

  task automatic test_div();
    logic [3:0]  es [12] = '{4'd1, 4'd2, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4,
                             4'd1, 4'd2, 4'd4, 4'd1};
    logic        dd [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                             1'b1, 1'b1, 1'b1, 1'b1};
    logic [14:0] ec [12] = '{C_FR, C_DS, C_DW0, C_DW0, C_DW0, C_DW0, C_DW0, C_DW1,
                             C_FR, C_DS, C_DW1, C_FR};
    int ds_cnt = 0;
    int rw_cnt = 0;
    apply_reset();
    op = 5'd8; mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); div_done = dd[i]; #1;
      checks++;
      if (state !== es[i] || ctl !== ec[i]) begin
        errors++;
        $display("FAIL div[%0d]: state=%0d ctl=%b, required state=%0d ctl=%b",
                 i, state, ctl, es[i], ec[i]);
      end
      ds_cnt += int'(div_start);
      rw_cnt += int'(regwrite);
    end
    checks++;
    if (ds_cnt != 2 || rw_cnt != 2) begin
      errors++;
      $display("FAIL div_pulse_count: div_start=%0d regwrite=%0d, required 2 and 2",
               ds_cnt, rw_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ops [13] = '{5'd9, 5'd9, 5'd9, 5'd15, 5'd15, 5'd15, 5'd12, 5'd12,
                              5'd12, 5'd13, 5'd13, 5'd13, 5'd0};
    logic [3:0]  es  [13] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd11, 4'd1, 4'd2,
                              4'd9, 4'd1, 4'd2, 4'd9, 4'd1};
    logic [14:0] ec  [13] = '{C_FR, C_NONE, C_EXR, C_FR, C_NONE, C_JMP, C_FR, C_NONE,
                              C_EXI, C_FR, C_NONE, C_EXI, C_FR};
    apply_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk); op = ops[i]; #1;
      checks++;
      if (state !== es[i] || ctl !== ec[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: state=%0d ctl=%b, required state=%0d ctl=%b",
                 i, state, ctl, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_illegal();
    int bad = 0;
    apply_reset();
    op = 5'd16; mem_ready = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd2 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_decode: state=%0d illegal=%b, required state=2 illegal=0",
               state, illegal);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); mem_ready = i[0]; div_done = i[1]; #1;
      if (state !== 4'd12 || illegal !== 1'b1 || bus_err !== 1'b0 || ctl !== C_NONE) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL illegal_hold: %0d of 20 cycles off, required state=12 illegal=1 ctl=0",
               bad);
    end
    #2 reset = 1'b1; #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_reset: state=%0d illegal=%b, required state=0 illegal=0",
               state, illegal);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_timeout();
    apply_reset();
    op = 5'd3; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (state !== 4'd1 || ctl !== C_FNR || bus_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: state=%0d ctl=%b bus_err=%b, required 1 %b 0",
                 i, state, ctl, bus_err, C_FNR);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd12 || bus_err !== 1'b1 || illegal !== 1'b0 || ctl !== C_NONE) begin
      errors++;
      $display("FAIL timeout_trap: state=%0d bus_err=%b illegal=%b ctl=%b, required 12 1 0 0",
               state, bus_err, illegal, ctl);
    end
  endtask

  task automatic test_timeout_race();
    apply_reset();
    op = 5'd3; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    @(negedge clk); mem_ready = 1'b1; #1;
    checks++;
    if (state !== 4'd1 || ctl !== C_FR) begin
      errors++;
      $display("FAIL race_fetch: state=%0d ctl=%b, required state=1 ctl=%b", state, ctl, C_FR);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd2 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL race_decode: state=%0d bus_err=%b, required state=2 bus_err=0",
               state, bus_err);
    end
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    op = 5'd11; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    @(negedge clk); mem_ready = 1'b0; #1;
    checks++;
    if (state !== 4'd7 || memwrite !== 1'b1 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL midwr_before: state=%0d memwrite=%b mem_req=%b, required 7 1 1",
               state, memwrite, mem_req);
    end
    #1 reset = 1'b1; #1;
    checks++;
    if (state !== 4'd0 || memwrite !== 1'b0 || mem_req !== 1'b0 || ctl !== C_NONE) begin
      errors++;
      $display("FAIL midwr_reset: state=%0d memwrite=%b mem_req=%b, required 0 0 0",
               state, memwrite, mem_req);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0; div_done = 1'b0;
    test_reset();
    test_add();
    test_load();
    test_store();
    test_branch();
    test_div();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_timeout_race();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
